// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, register sentinel, fetch FSM states and the
// per-icode instruction-shape helpers used by fetch and decode-side checkers.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_CONST,
        ST_DONE
    } fetch_state_e;

    function automatic logic f_need_regids(input logic [3:0] icode);
        return icode inside {ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
                             ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ};
    endfunction

    function automatic logic f_need_valc(input logic [3:0] icode);
        return icode inside {ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_JXX, ICODE_CALL};
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational icode classifier: which optional bytes follow byte0, and whether the
// icode is outside the legal range.
module instr_len_decode
    import y86_pkg::*;
#(
    parameter logic [3:0] MAX_ICODE = ICODE_POPQ
) (
    input  logic [3:0] icode,
    output logic       need_regids,
    output logic       need_valc,
    output logic       illegal
);

    assign need_regids = f_need_regids(icode);
    assign need_valc   = f_need_valc(icode);
    assign illegal     = (icode > MAX_ICODE);

endmodule

// File: rtl/y86_fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetcher with a single outstanding memory read.
// Define FETCH_AUTO_ADVANCE_EN to chain fetches from valP on acceptance until halt/error.
module y86_fetch_sequencer
    import y86_pkg::*;
#(
    parameter int         ADDR_W    = 64,
    parameter logic [3:0] MAX_ICODE = ICODE_POPQ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_err,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [2:0]        cnt_q;
    logic              wait_q;
    logic              rsp;
    logic              launch;
    logic              advance;
    logic [3:0]        dec_icode;
    logic              need_regids, need_valc, illegal;

    // Only a response to our own outstanding request counts; anything else is noise.
    assign rsp = wait_q & mem_rvalid;

    // In HDR the icode is still on the bus; afterwards it is held in the output register.
    assign dec_icode = (state_q == ST_HDR) ? mem_rdata[7:4] : icode;

    instr_len_decode #(.MAX_ICODE(MAX_ICODE)) u_len_decode (
        .icode       (dec_icode),
        .need_regids (need_regids),
        .need_valc   (need_valc),
        .illegal     (illegal)
    );

`ifdef FETCH_AUTO_ADVANCE_EN
    assign advance = (icode != ICODE_HALT) && !instr_err;
`else
    assign advance = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_HDR;
            ST_HDR: begin
                if (rsp) begin
                    if (illegal)          state_d = ST_DONE;
                    else if (need_regids) state_d = ST_REG;
                    else if (need_valc)   state_d = ST_CONST;
                    else                  state_d = ST_DONE;
                end
            end
            ST_REG:   if (rsp) state_d = need_valc ? ST_CONST : ST_DONE;
            ST_CONST: if (rsp && (cnt_q == 3'd7)) state_d = ST_DONE;
            ST_DONE:  if (instr_ready) state_d = advance ? ST_HDR : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        launch    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc_in;
                    launch    = 1'b1;
                end
            end
            ST_REG, ST_CONST: begin
                if (!wait_q) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cur_addr_q;
                end
            end
            ST_DONE: begin
                if (instr_ready && advance) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cur_addr_q;
                    launch    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign instr_valid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    // cur_addr always points at the byte after the last one retired, i.e. PC + length so far.
    assign valP        = cur_addr_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_q <= '0;
            cnt_q      <= '0;
            wait_q     <= 1'b0;
            icode      <= '0;
            ifun       <= '0;
            rA         <= REG_NONE;
            rB         <= REG_NONE;
            valC       <= '0;
            instr_err  <= 1'b0;
        end else begin
            if (launch) begin
                if (state_q == ST_IDLE) cur_addr_q <= pc_in;
                wait_q    <= 1'b1;
                cnt_q     <= '0;
                icode     <= '0;
                ifun      <= '0;
                rA        <= REG_NONE;
                rB        <= REG_NONE;
                valC      <= '0;
                instr_err <= 1'b0;
            end else if (mem_rd_en) begin
                wait_q <= 1'b1;
            end

            if (rsp) begin
                wait_q     <= 1'b0;
                cur_addr_q <= cur_addr_q + ADDR_W'(1);
                unique case (state_q)
                    ST_HDR: begin
                        icode     <= mem_rdata[7:4];
                        ifun      <= mem_rdata[3:0];
                        instr_err <= illegal;
                    end
                    ST_REG: begin
                        rA <= mem_rdata[7:4];
                        rB <= mem_rdata[3:0];
                    end
                    ST_CONST: begin
                        valC[{cnt_q, 3'b000} +: 8] <= mem_rdata;
                        cnt_q                      <= cnt_q + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
